// File: rtl/int_dispatcher_pkg.sv
// Shared parameters and FSM state encoding for the interrupt dispatcher.
`timescale 1ns/1ps
package int_dispatcher_pkg;

    localparam int N_INTS_DEF      = 256;
    localparam int ID_W_DEF        = 8;
    localparam int ACK_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        S_SETTLE  = 2'd0,
        S_IDLE    = 2'd1,
        S_REQ     = 2'd2,
        S_SERVICE = 2'd3
    } state_e;

endpackage

// File: rtl/int_dispatcher_if.sv
// Bundle of device, interrupt-controller, CPU and mask-write signals around the dispatcher.
`timescale 1ns/1ps
interface int_dispatcher_if
    import int_dispatcher_pkg::*;
#(
    parameter int N_INTS = N_INTS_DEF,
    parameter int ID_W   = ID_W_DEF
);
    logic [N_INTS-1:0] dev_ints;
    logic [N_INTS-1:0] ic_ints;
    logic              ic_enable;
    logic              ic_available;
    logic [ID_W-1:0]   ic_dev_id;
    logic              cpu_ie;
    logic              irq;
    logic [ID_W-1:0]   irq_vector;
    logic              cpu_ack;
    logic              cpu_eoi;
    logic              in_service;
    logic              timeout;
    logic              mask_we;
    logic [ID_W-1:0]   mask_id;
    logic              mask_set;

    // Dispatcher side
    modport master (
        input  dev_ints, ic_available, ic_dev_id, cpu_ie, cpu_ack, cpu_eoi,
               mask_we, mask_id, mask_set,
        output ic_ints, ic_enable, irq, irq_vector, in_service, timeout
    );

    // Environment side: devices, ic and CPU core
    modport slave (
        output dev_ints, ic_available, ic_dev_id, cpu_ie, cpu_ack, cpu_eoi,
               mask_we, mask_id, mask_set,
        input  ic_ints, ic_enable, irq, irq_vector, in_service, timeout
    );

endinterface

// File: rtl/int_dispatcher_mask_reg.sv
// Software mask plus the auto-mask of the in-service source; gates raw device lines.
`timescale 1ns/1ps
module int_dispatcher_mask_reg
    import int_dispatcher_pkg::*;
#(
    parameter int N_INTS = N_INTS_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ID_W-1:0]   i_id,
    input  logic              i_set,
    input  logic              i_auto_set,
    input  logic              i_auto_clr,
    input  logic [ID_W-1:0]   i_auto_id,
    input  logic [N_INTS-1:0] i_lines,
    output logic [N_INTS-1:0] o_lines
);
    logic [N_INTS-1:0] r_sw_mask;
    logic [N_INTS-1:0] r_auto_mask;
    logic              w_id_ok;

    assign w_id_ok = (int'(i_id) < N_INTS);

    // NOTE: both masks are control state, not storage, so they are reset to a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_mask   <= '0;
            r_auto_mask <= '0;
        end else begin
            if (i_we && w_id_ok)
                r_sw_mask[i_id] <= i_set;
            if (i_auto_set)
                r_auto_mask[i_auto_id] <= 1'b1;
            else if (i_auto_clr)
                r_auto_mask[i_auto_id] <= 1'b0;
        end
    end

    assign o_lines = i_lines & ~(r_sw_mask | r_auto_mask);

endmodule

// File: rtl/int_dispatcher.sv
// Sequences the interrupt controller and hands one interrupt at a time to the CPU core.
`timescale 1ns/1ps
module int_dispatcher
    import int_dispatcher_pkg::*;
#(
    parameter int N_INTS      = N_INTS_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rst,
    int_dispatcher_if.master bus
);
    localparam int                CNT_W   = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_vec;
    logic              r_irq;
    logic              r_in_service;
    logic              r_timeout;
    logic              w_auto_set;
    logic              w_auto_clr;
    logic [N_INTS-1:0] w_ic_ints;

    assign w_auto_set = (r_state == S_REQ) && bus.cpu_ack;
    assign w_auto_clr = (r_state == S_SERVICE) && bus.cpu_eoi;

    int_dispatcher_mask_reg #(.N_INTS(N_INTS), .ID_W(ID_W)) u_mask (
        .clk        (clk),
        .rst        (rst),
        .i_we       (bus.mask_we),
        .i_id       (bus.mask_id),
        .i_set      (bus.mask_set),
        .i_auto_set (w_auto_set),
        .i_auto_clr (w_auto_clr),
        .i_auto_id  (r_vec),
        .i_lines    (bus.dev_ints),
        .o_lines    (w_ic_ints)
    );

    // NOTE: sequential state uses <= only, so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SETTLE;
            r_cnt        <= '0;
            r_vec        <= '0;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_SETTLE: r_state <= S_IDLE;
                S_IDLE: begin
                    if (bus.ic_available && bus.cpu_ie) begin
                        r_vec   <= bus.ic_dev_id;
                        r_cnt   <= '0;
                        r_irq   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (r_cnt != CNT_MAX)
                        r_cnt <= r_cnt + 1'b1;
                    if (bus.cpu_ack) begin
                        r_irq        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
                    end else if (!bus.cpu_ie) begin
                        r_irq   <= 1'b0;
                        r_state <= S_SETTLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_irq     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SERVICE: begin
                    if (bus.cpu_eoi) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_SETTLE;
                    end
                end
                default: r_state <= S_SETTLE;
            endcase
        end
    end

    // ic only samples while no request is outstanding
    assign bus.ic_enable  = (r_state == S_SETTLE) || (r_state == S_IDLE);
    assign bus.ic_ints    = w_ic_ints;
    assign bus.irq        = r_irq;
    assign bus.irq_vector = r_vec;
    assign bus.in_service = r_in_service;
    assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_int_dispatcher.sv
// Self-checking bench: behavioural ic model, directed scenarios, then randomized mask/line patterns.
`timescale 1ns/1ps
module tb_int_dispatcher;
    import int_dispatcher_pkg::*;

    localparam int N  = 256;
    localparam int IW = 8;
    localparam int TO = 1024;

    typedef logic [N-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_dispatcher_if #(.N_INTS(N), .ID_W(IW)) bus ();

    int_dispatcher #(.N_INTS(N), .ID_W(IW), .ACK_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    vec_t sw_model;

    function automatic logic [IW-1:0] hi_idx(input vec_t v);
        logic [IW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) r = IW'(i);
        return r;
    endfunction

    // Interrupt controller: registers highest pending line while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ic_available <= 1'b0;
            bus.ic_dev_id    <= '0;
        end else if (bus.ic_enable) begin
            bus.ic_available <= |bus.ic_ints;
            bus.ic_dev_id    <= hi_idx(bus.ic_ints);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string tag, input int bound);
        int n = 0;
        while (bus.irq !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, vec_t'(bus.irq), vec_t'(1));
    endtask

    task automatic set_mask(input int id, input logic set);
        bus.mask_we  = 1'b1;
        bus.mask_id  = IW'(id);
        bus.mask_set = set;
        tick();
        bus.mask_we  = 1'b0;
        sw_model[id] = set;
    endtask

    task automatic ack();
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
    endtask

    task automatic eoi();
        bus.cpu_eoi = 1'b1;
        tick();
        bus.cpu_eoi = 1'b0;
    endtask

    initial begin
        vec_t          pat;
        vec_t          exp_lines;
        vec_t          one_hot;
        logic [IW-1:0] exp_vec;
        int            n_hi;
        int            n_to;
        int            n;
        int            pb [3];

        sw_model     = '0;
        bus.dev_ints = '0;
        bus.cpu_ie   = 1'b1;
        bus.cpu_ack  = 1'b0;
        bus.cpu_eoi  = 1'b0;
        bus.mask_we  = 1'b0;
        bus.mask_id  = '0;
        bus.mask_set = 1'b0;

        // 1. reset and quiet idle
        rst = 1'b1;
        tick();
        tick();
        check("rst_irq", vec_t'(bus.irq), vec_t'(0));
        check("rst_vec", vec_t'(bus.irq_vector), vec_t'(0));
        check("rst_ic_en", vec_t'(bus.ic_enable), vec_t'(1));
        check("rst_in_svc", vec_t'(bus.in_service), vec_t'(0));
        check("rst_timeout", vec_t'(bus.timeout), vec_t'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_irq", vec_t'(bus.irq), vec_t'(0));
            check("idle_ic_en", vec_t'(bus.ic_enable), vec_t'(1));
            check("idle_in_svc", vec_t'(bus.in_service), vec_t'(0));
        end

        // 2. priority, auto-mask, re-dispatch after EOI
        bus.dev_ints[0] = 1'b1;
        bus.dev_ints[3] = 1'b1;
        wait_irq("t2_irq", 8);
        check("t2_vec3", vec_t'(bus.irq_vector), vec_t'(3));
        check("t2_ic_en_low", vec_t'(bus.ic_enable), vec_t'(0));
        ack();
        check("t2_in_svc", vec_t'(bus.in_service), vec_t'(1));
        check("t2_irq_low", vec_t'(bus.irq), vec_t'(0));
        check("t2_ic_ints3", vec_t'(bus.ic_ints[3]), vec_t'(0));
        check("t2_ic_ints0", vec_t'(bus.ic_ints[0]), vec_t'(1));
        bus.dev_ints[3] = 1'b0;
        eoi();
        check("t2_eoi", vec_t'(bus.in_service), vec_t'(0));
        wait_irq("t2_irq2", 8);
        check("t2_vec0", vec_t'(bus.irq_vector), vec_t'(0));
        ack();
        bus.dev_ints = '0;
        eoi();
        tick();

        // 3. unacked request times out once, then re-raises
        bus.dev_ints[5] = 1'b1;
        wait_irq("t3_irq", 8);
        n_hi = 1;
        n_to = 0;
        while (n_hi < 2 * TO) begin
            tick();
            if (bus.timeout === 1'b1) n_to++;
            if (bus.irq !== 1'b1) break;
            n_hi++;
        end
        check("t3_irq_cycles", vec_t'(n_hi), vec_t'(TO));
        check("t3_timeout_pulse", vec_t'(n_to), vec_t'(1));
        tick();
        check("t3_timeout_once", vec_t'(bus.timeout), vec_t'(0));
        wait_irq("t3_reraise", 8);
        check("t3_vec5", vec_t'(bus.irq_vector), vec_t'(5));

        // 5. ignored strobes and ie drop
        eoi();
        check("t5_eoi_in_req_irq", vec_t'(bus.irq), vec_t'(1));
        check("t5_eoi_in_req_svc", vec_t'(bus.in_service), vec_t'(0));
        bus.cpu_ie = 1'b0;
        tick();
        check("t5_ie_drop_irq", vec_t'(bus.irq), vec_t'(0));
        check("t5_ie_drop_no_to", vec_t'(bus.timeout), vec_t'(0));
        repeat (5) tick();
        check("t5_ie_off_quiet", vec_t'(bus.irq), vec_t'(0));
        bus.cpu_ie = 1'b1;
        wait_irq("t5_irq_ie_on", 8);
        ack();
        check("t5_in_svc", vec_t'(bus.in_service), vec_t'(1));
        ack();
        check("t5_spur_ack_svc", vec_t'(bus.in_service), vec_t'(1));
        check("t5_spur_ack_irq", vec_t'(bus.irq), vec_t'(0));
        check("t5_spur_ack_vec", vec_t'(bus.irq_vector), vec_t'(5));
        bus.dev_ints = '0;
        eoi();
        check("t5_eoi", vec_t'(bus.in_service), vec_t'(0));
        tick();

        // 4. software mask, unmask latency, mask interplay with auto-mask
        set_mask(7, 1'b1);
        bus.dev_ints[7] = 1'b1;
        repeat (8) tick();
        check("t4_masked_quiet", vec_t'(bus.irq), vec_t'(0));
        set_mask(7, 1'b0);
        n = 0;
        while (bus.irq !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        check("t4_unmask_irq", vec_t'(bus.irq), vec_t'(1));
        check("t4_vec7", vec_t'(bus.irq_vector), vec_t'(7));
        ack();
        set_mask(7, 1'b1);
        set_mask(7, 1'b0);
        check("t4_auto_kept", vec_t'(bus.ic_ints[7]), vec_t'(0));
        set_mask(7, 1'b1);
        eoi();
        repeat (6) tick();
        check("t4_masked_after_eoi", vec_t'(bus.ic_ints[7]), vec_t'(0));
        check("t4_no_irq_after_eoi", vec_t'(bus.irq), vec_t'(0));
        set_mask(7, 1'b0);
        bus.dev_ints = '0;
        tick();

        // 6. reset during SERVICE
        set_mask(2, 1'b1);
        bus.dev_ints[9] = 1'b1;
        bus.dev_ints[2] = 1'b1;
        wait_irq("t6_irq", 8);
        check("t6_vec9", vec_t'(bus.irq_vector), vec_t'(9));
        ack();
        check("t6_in_svc", vec_t'(bus.in_service), vec_t'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sw_model = '0;
        check("t6_rst_in_svc", vec_t'(bus.in_service), vec_t'(0));
        check("t6_rst_irq", vec_t'(bus.irq), vec_t'(0));
        check("t6_rst_ic_ints", bus.ic_ints, bus.dev_ints);
        wait_irq("t6_reraise", 8);
        check("t6_vec9b", vec_t'(bus.irq_vector), vec_t'(9));
        ack();
        bus.dev_ints = '0;
        eoi();
        tick();

        // Randomized: highest unmasked line wins; auto-mask hides only the served line
        for (int it = 0; it < 40; it++) begin
            pat = '0;
            for (int k = 0; k < 3; k++) begin
                pb[k] = $urandom_range(0, N - 1);
                pat[pb[k]] = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 1) == 1)
                    set_mask(pb[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
                else
                    set_mask($urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
            end
            exp_lines    = pat & ~sw_model;
            bus.dev_ints = pat;
            if (exp_lines == '0) begin
                repeat (6) tick();
                check("rnd_no_irq", vec_t'(bus.irq), vec_t'(0));
            end else begin
                exp_vec = hi_idx(exp_lines);
                wait_irq("rnd_irq", 8);
                check("rnd_vec", vec_t'(bus.irq_vector), vec_t'(exp_vec));
                ack();
                check("rnd_in_svc", vec_t'(bus.in_service), vec_t'(1));
                one_hot          = '0;
                one_hot[exp_vec] = 1'b1;
                check("rnd_ic_ints", bus.ic_ints, exp_lines & ~one_hot);
                bus.dev_ints = '0;
                eoi();
                check("rnd_eoi", vec_t'(bus.in_service), vec_t'(0));
            end
            bus.dev_ints = '0;
            tick();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
